// File: rtl/regfile_write_decoder.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_decoder
// Description : Write side of a 32-entry register file: tree-decoded one-hot
//               write enable, enabled-DFF storage, hardwired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_decoder #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [WIDTH-1:0]      WriteData,
    output logic [31:0]           enable,
    output logic [32*WIDTH-1:0]   regs,
    output logic                  wr_done,
    output logic [4:0]            last_reg
);

    localparam logic [4:0] c_ZERO_IDX = 5'(ZERO_REG);

    logic [3:0] w_hi;
    logic [7:0] w_lo;
    logic       wr_done_d;
    logic       wr_done_q;
    logic [4:0] last_reg_d;
    logic [4:0] last_reg_q;

    // RegWrite gates the 2:4 stage, so an X register number cannot leak
    // into any enable while no write is requested.
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        for (int i = 0; i < 4; i++) begin
            w_hi[i] = RegWrite & (WriteRegister[4:3] == 2'(i));
        end
        for (int j = 0; j < 8; j++) begin
            w_lo[j] = (WriteRegister[2:0] == 3'(j));
        end
    end

    always_comb begin
        enable = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 8; j++) begin
                enable[8*i+j] = w_hi[i] & w_lo[j];
            end
        end
        enable[c_ZERO_IDX] = 1'b0;
    end

    genvar k;
    generate
        for (k = 0; k < 32; k++) begin : g_reg
            if (k == ZERO_REG) begin : g_zero
                assign regs[k*WIDTH +: WIDTH] = '0;
            end else begin : g_store
                logic [WIDTH-1:0] data_d;
                logic [WIDTH-1:0] data_q;

                assign data_d = enable[k] ? WriteData : data_q;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        data_q <= '0;
                    end else begin
                        data_q <= data_d;
                    end
                end

                assign regs[k*WIDTH +: WIDTH] = data_q;
            end
        end
    endgenerate

    assign wr_done_d  = RegWrite & (WriteRegister != c_ZERO_IDX);
    assign last_reg_d = wr_done_d ? WriteRegister : last_reg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_done_q  <= 1'b0;
            last_reg_q <= '0;
        end else begin
            wr_done_q  <= wr_done_d;
            last_reg_q <= last_reg_d;
        end
    end

    assign wr_done  = wr_done_q;
    assign last_reg = last_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_decoder
// Description : Vector table plus reference model for regfile_write_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_decoder;

    localparam int W = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             RegWrite;
    logic [4:0]       WriteRegister;
    logic [W-1:0]     WriteData;
    logic [31:0]      enable;
    logic [32*W-1:0]  regs;
    logic             wr_done;
    logic [4:0]       last_reg;

    regfile_write_decoder #(.WIDTH(W), .ZERO_REG(31)) dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .enable        (enable),
        .regs          (regs),
        .wr_done       (wr_done),
        .last_reg      (last_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         rw;
        logic [4:0]   wr;
        logic [W-1:0] wd;
        logic [31:0]  exp_en;
    } vec_t;

    typedef struct {
        logic [32*W-1:0] regs;
        logic            done;
        logic [4:0]      last;
    } exp_t;

    vec_t         vecs[$];
    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;

    logic [W-1:0] m_regs[32];
    logic         m_done = 1'b0;
    logic [4:0]   m_last = '0;
    bit           m_init = 1'b0;

    function automatic logic [31:0] dec(input logic rw, input logic [4:0] wr);
        logic [31:0] one;
        one = 32'h1;
        if (rw && wr != 5'd31) return one << wr;
        return 32'h0;
    endfunction

    function automatic logic [32*W-1:0] flat();
        logic [32*W-1:0] f;
        for (int i = 0; i < 32; i++) f[i*W +: W] = m_regs[i];
        return f;
    endfunction

    function automatic void add(input logic rst, input logic rw,
                                input logic [4:0] wr, input logic [W-1:0] wd);
        vec_t v;
        v.rst = rst; v.rw = rw; v.wr = wr; v.wd = wd;
        v.exp_en = dec(rw, wr);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name, input logic [32*W-1:0] exp);
        int bad;
        bad = -1;
        checks++;
        for (int i = 31; i >= 0; i--) begin
            if (regs[i*W +: W] !== exp[i*W +: W]) bad = i;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: X%0d got %h expected %h", name, bad,
                     regs[bad*W +: W], exp[bad*W +: W]);
        end
    endtask

    task automatic step(input logic rst, input logic rw, input logic [4:0] wr,
                        input logic [W-1:0] wd, input logic [31:0] exp_en, input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst; RegWrite = rw; WriteRegister = wr; WriteData = wd;
        #1;
        check({tag, " enable"}, W'(enable), W'(exp_en));
        // Before the edge the written register must still show its old value.
        if (m_init) check_regs({tag, " pre-edge"}, flat());
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_done = 1'b0;
            m_last = '0;
            m_init = 1'b1;
        end else begin
            m_done = rw && (wr != 5'd31);
            if (m_done) begin
                m_regs[wr] = wd;
                m_last = wr;
            end
        end
        e.regs = flat(); e.done = m_done; e.last = m_last;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_regs({tag, " regs"}, e.regs);
        check({tag, " wr_done"}, W'(wr_done), W'(e.done));
        check({tag, " last_reg"}, W'(last_reg), W'(e.last));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int bnd[8];
        bnd = '{0, 7, 8, 15, 16, 23, 24, 30};
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;

        add(1'b1, 1'b0, 5'($urandom), {$urandom, $urandom});
        add(1'b1, 1'b0, 5'($urandom), {$urandom, $urandom});
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 5'($urandom), {$urandom, $urandom});
        for (int i = 0; i <= 30; i++) add(1'b0, 1'b1, 5'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
        add(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        add(1'b0, 1'b1, 5'd10, 64'd5);
        add(1'b0, 1'b1, 5'd10, 64'd7);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 5'd10, 64'd9);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 5'(bnd[i]), {32'hB00D_0000, 32'(bnd[i])});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].exp_en,
                 $sformatf("vec%0d", i));
        end

        // Reset colliding with a write, then the first write after reset.
        step(1'b0, 1'b1, 5'd4,  64'h1234, dec(1'b1, 5'd4),  "load X4");
        step(1'b0, 1'b1, 5'd20, 64'h5678, dec(1'b1, 5'd20), "load X20");
        step(1'b1, 1'b1, 5'd4,  64'h9999, dec(1'b1, 5'd4),  "reset+write");
        check("X4 after reset", regs[4*W +: W], 64'h0);
        check("X20 after reset", regs[20*W +: W], 64'h0);
        step(1'b0, 1'b1, 5'd4,  64'h1, dec(1'b1, 5'd4),     "post-reset write");
        check("X4 post-reset", regs[4*W +: W], 64'h1);
        check("last_reg post-reset", W'(last_reg), 64'd4);
        step(1'b0, 1'b0, 5'd0,  64'h0, 32'h0,               "final idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
